alarm_button_ctrl: RTL and testbench
====================================

# alarm_button_ctrl

Debounce and event controller for the four alarm-clock push buttons. It sits between the raw active-low key pins and the Nios II Avalon-MM bus, and replaces direct level sampling with clean press events. It synchronizes and debounces each key, detects presses, and generates auto-repeat events while a key is held (for fast time/alarm setting). Events latch into a sticky capture register, and a maskable interrupt is raised while any enabled event is pending.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable synchronized samples required to accept a level change (1 ms at 50 MHz); ≥2
- HOLD_CYCLES, 25000000, pressed cycles before the first repeat event; ≥2
- REPEAT_CYCLES, 5000000, cycles between subsequent repeat events; ≥2
- clk  in  1  system clock; the block uses this single clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- in_port  in  4  raw key pins, active-low (0 = pressed), asynchronous
- readdata  out  32  registered read data
- irq  out  1  interrupt request, active-high

## Operation
- Register map; unused bits read 0:
  - 0 DATA (RO): [3:0] debounced pressed level, 1 = pressed
  - 1 MASK (RW): [7:0] interrupt enable
  - 2 EVENT (RW1C): [3:0] press events, [7:4] repeat events
  - 3 STATUS (RO): [3:0] held flags, 1 = key is in the repeat phase
- Synchronizer: two flops per key. Both reset to 1 (released).
- Debounce, per key: the synchronized sample s is compared with the stable level.
  - If they are equal, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with s still different, the stable level takes s and the counter clears.
  - Any single equal sample restarts the count.
- Per-key FSM:
  - RELEASED: on a stable-press transition, set EVENT[i] on that same edge and go to PRESSED with the hold counter at 0.
  - PRESSED: the hold counter increments each cycle. At HOLD_CYCLES-1, set EVENT[4+i], clear the counter and go to HELD.
  - HELD: STATUS[i]=1. The counter increments. At REPEAT_CYCLES-1, set EVENT[4+i] and clear the counter.
  - From PRESSED or HELD, a stable-release transition returns to RELEASED and clears the counter. Releases generate no event.
- EVENT bits are sticky. A write to address 2 clears each bit written as 1. If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK write: MASK ← writedata[7:0].
- Writes to addresses 0 and 3 are ignored.
- irq = |(EVENT & MASK). It is combinational from registers.
- Counter widths: $clog2 of the respective parameter. Counters never wrap; they saturate at their terminal value.
- Reset values: all flags, counters, EVENT, MASK, readdata and irq are 0. Every FSM is in RELEASED. Synchronizer flops are 1.
- Reset asserted mid-press or mid-hold discards the state. A key still held after reset must be re-debounced, and it produces a fresh press event.

## Timing
- readdata updates every clock from address, independent of chipselect: 1-cycle read latency, no wait states.
- Write effects are visible on the next cycle; a read issued on the cycle after a write returns the new value.
- in_port edge to DATA/EVENT update: 2 + DEBOUNCE_CYCLES cycles for a clean edge.
- Stable press to the first repeat event: HOLD_CYCLES cycles. Later repeats follow every REPEAT_CYCLES cycles.
- irq rises the same cycle the enabled EVENT bit sets. It falls the cycle after the clearing write or mask write.
- Keys are fully independent. Simultaneous events on multiple keys all latch in one cycle.

## Test plan
Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8.
- Clean press: drive in_port=0xE from 0xF. DATA reads 0x1 and EVENT=0x01 exactly 6 cycles later. Then release: DATA returns to 0x0 6 cycles later, EVENT is unchanged.
- Bounce: toggle in_port[1] every 3 cycles for 30 cycles, then hold it low. Exactly one press event (EVENT=0x02) latches, 6 cycles after the final edge. DATA shows no glitches.
- Hold/repeat: hold key 2 and write 0xFF to address 2 after each event. EVENT[6] sets at 20, 28 and 36 cycles after the stable press. STATUS=0x4 from cycle 20. Release clears STATUS and stops the repeats.
- Clear race: issue a W1C of 0x01 in the same cycle key 0's press event sets. EVENT[0] remains 1.
- Interrupt mask: set MASK=0x02. Pressing key 0 leaves irq=0; pressing key 1 raises irq in the cycle EVENT[1] sets. Writing 0x02 to EVENT drops irq on the next cycle.
- Reset mid-hold: assert reset for 1 cycle while key 3 is held in HELD. All outputs read 0 and irq=0. DATA[3] and EVENT[3] reassert 6 cycles after reset deasserts.

Source files
------------

// File: rtl/alarm_button_ctrl_if.sv
// Avalon-MM slave bus bundle for the alarm-clock button controller.
// The CPU side drives address/strobe/data; the controller returns registered read data.
interface alarm_button_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/alarm_button_ctrl.sv
// Debounce and event controller for the four alarm-clock push buttons.
// Raw active-low keys are synchronized, debounced, turned into press and
// auto-repeat events, latched in a sticky W1C register and gated onto irq.
module alarm_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                       clk,
  input  logic                       reset,
  alarm_button_ctrl_if.slave         bus,
  input  logic [3:0]                 in_port,
  output logic                       irq
);

  localparam int NUM_KEYS = 4;

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // One hold/repeat counter per key serves both phases, so size it for the larger.
  localparam int HOLD_W = (HOLD_CYCLES   > 2) ? $clog2(HOLD_CYCLES)   : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam int HC_W   = (HOLD_W > REP_W) ? HOLD_W : REP_W;

  localparam logic [DB_W-1:0] DB_TERM   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_TERM = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] REP_TERM  = HC_W'(REPEAT_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_EVENT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } key_state_t;

  // Two-stage synchronizer, raw pin polarity (1 = released).
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  // Per-key results gathered from the generate loop.
  logic [NUM_KEYS-1:0] w_data;        // debounced level, 1 = pressed
  logic [NUM_KEYS-1:0] w_held;        // key is in the repeat phase
  logic [NUM_KEYS-1:0] w_press_evt;   // single-cycle press pulse
  logic [NUM_KEYS-1:0] w_repeat_evt;  // single-cycle repeat pulse

  // Register file.
  logic [7:0]  r_mask;
  logic [7:0]  r_event;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic [7:0]  w_event_set;
  logic [7:0]  w_event_clr;
  logic [7:0]  w_event_next;
  logic [31:0] w_rd_mux;
  logic        w_wdata_unused;

  // Bring the asynchronous key pins into the clock domain; reset to "released".
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [DB_W-1:0] r_db_cnt;
      logic            r_stable;
      logic            w_sample;
      logic            w_differ;
      logic            w_accept;
      logic            w_rise;
      logic            w_fall;

      key_state_t      r_state;
      key_state_t      w_state_next;
      logic [HC_W-1:0] r_hold_cnt;
      logic [HC_W-1:0] w_hold_cnt_next;
      logic            w_press;
      logic            w_repeat;
      logic            w_held_k;

      // Work in "pressed = 1" polarity from here on.
      assign w_sample = ~r_sync2[gi];
      assign w_differ = (w_sample != r_stable);
      // The stable level flips on the edge where the counter sits at its
      // terminal value and the sample still disagrees.
      assign w_accept = w_differ && (r_db_cnt == DB_TERM);
      assign w_rise   = w_accept &&  w_sample;
      assign w_fall   = w_accept && !w_sample;

      // Debounce: count consecutive disagreeing samples, any agreement restarts.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_db_cnt <= '0;
          r_stable <= 1'b0;
        end else if (!w_differ) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= w_sample;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end

      // Key FSM state and hold/repeat counter registers.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_state    <= ST_RELEASED;
          r_hold_cnt <= '0;
        end else begin
          r_state    <= w_state_next;
          r_hold_cnt <= w_hold_cnt_next;
        end
      end

      // Key FSM next state and event pulses; a release always wins over a
      // repeat landing on the same edge, and produces no event itself.
      always_comb begin
        w_state_next    = r_state;
        w_hold_cnt_next = r_hold_cnt;
        w_press         = 1'b0;
        w_repeat        = 1'b0;
        w_held_k        = 1'b0;
        case (r_state)
          ST_RELEASED: begin
            if (w_rise) begin
              w_press         = 1'b1;
              w_state_next    = ST_PRESSED;
              w_hold_cnt_next = '0;
            end
          end
          ST_PRESSED: begin
            if (w_fall) begin
              w_state_next    = ST_RELEASED;
              w_hold_cnt_next = '0;
            end else if (r_hold_cnt == HOLD_TERM) begin
              w_repeat        = 1'b1;
              w_state_next    = ST_HELD;
              w_hold_cnt_next = '0;
            end else begin
              w_hold_cnt_next = r_hold_cnt + HC_W'(1);
            end
          end
          ST_HELD: begin
            w_held_k = 1'b1;
            if (w_fall) begin
              w_state_next    = ST_RELEASED;
              w_hold_cnt_next = '0;
            end else if (r_hold_cnt == REP_TERM) begin
              w_repeat        = 1'b1;
              w_hold_cnt_next = '0;
            end else begin
              w_hold_cnt_next = r_hold_cnt + HC_W'(1);
            end
          end
          default: begin
            w_state_next    = ST_RELEASED;
            w_hold_cnt_next = '0;
          end
        endcase
      end

      assign w_data[gi]       = r_stable;
      assign w_held[gi]       = w_held_k;
      assign w_press_evt[gi]  = w_press;
      assign w_repeat_evt[gi] = w_repeat;
    end
  endgenerate

  // Bus write decode and sticky event update; a set beats a same-cycle clear.
  always_comb begin
    w_wr         = bus.chipselect && !bus.write_n;
    w_event_set  = {w_repeat_evt, w_press_evt};
    w_event_clr  = (w_wr && (bus.address == ADDR_EVENT)) ? bus.writedata[7:0] : 8'h00;
    w_event_next = (r_event & ~w_event_clr) | w_event_set;
  end

  // Only the low byte of write data is meaningful.
  assign w_wdata_unused = &{1'b0, bus.writedata[31:8]};

  // MASK and EVENT registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask  <= 8'h00;
      r_event <= 8'h00;
    end else begin
      r_event <= w_event_next;
      if (w_wr && (bus.address == ADDR_MASK)) begin
        r_mask <= bus.writedata[7:0];
      end
    end
  end

  // Read mux; address is decoded every cycle regardless of chipselect.
  always_comb begin
    w_rd_mux = 32'h0;
    case (bus.address)
      ADDR_DATA:   w_rd_mux = {28'h0, w_data};
      ADDR_MASK:   w_rd_mux = {24'h0, r_mask};
      ADDR_EVENT:  w_rd_mux = {24'h0, r_event};
      ADDR_STATUS: w_rd_mux = {28'h0, w_held};
      default:     w_rd_mux = 32'h0;
    endcase
  end

  // Registered read data gives a fixed one-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_readdata <= 32'h0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

  assign bus.readdata = r_readdata;
  assign irq          = |(r_event & r_mask);

endmodule

// File: tb/tb_alarm_button_ctrl.sv
// Self-checking bench for alarm_button_ctrl with short debounce/hold/repeat times.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_alarm_button_ctrl;

  localparam int DB  = 4;
  localparam int HLD = 20;
  localparam int REP = 8;

  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  logic       irq;

  int n_checks = 0;
  int n_pass   = 0;

  alarm_button_ctrl_if bus_if ();

  alarm_button_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    tick();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    $display("wr   addr=%0d data=0x%08h", a, d);
  endtask

  // Expected value is queued when the read is issued and compared when
  // the registered read data comes back one cycle later.
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
    sb_t item;
    bus_if.address = a;
    item.name = nm;
    item.exp  = exp;
    sb_q.push_back(item);
    tick();
    item = sb_q.pop_front();
    $display("rd   addr=%0d data=0x%08h", a, bus_if.readdata);
    check(item.name, bus_if.readdata, item.exp);
  endtask

  function automatic logic is_evt(input int e);
    return (e == 6) || (e == 26) || (e == 34) || (e == 42);
  endfunction

  initial begin
    // do_wr, write addr, write data, read addr, expected read, name
    vecs[0]  = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0,  "rst_data"};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0,  "rst_mask"};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0,  "rst_event"};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0,  "rst_status"};
    vecs[4]  = '{1'b1, 2'd1, 32'hA5,        2'd1, 32'hA5, "mask_a5"};
    vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FF3C, 2'd1, 32'h3C, "mask_upper_bits"};
    vecs[6]  = '{1'b1, 2'd0, 32'hF,         2'd0, 32'h0,  "data_readonly"};
    vecs[7]  = '{1'b1, 2'd3, 32'hF,         2'd3, 32'h0,  "status_readonly"};
    vecs[8]  = '{1'b1, 2'd0, 32'hFF,        2'd1, 32'h3C, "mask_kept"};
    vecs[9]  = '{1'b1, 2'd2, 32'hFF,        2'd2, 32'h0,  "event_w1c_empty"};
    vecs[10] = '{1'b1, 2'd1, 32'hFF,        2'd1, 32'hFF, "mask_all"};

    reset             = 1'b1;
    in_port           = 4'hF;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = 32'h0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_readdata", bus_if.readdata, 32'h0);
    check("rst_irq", irq, 1'b0);

    // Register access table.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].wa, vecs[i].wd);
      rd(vecs[i].ra, vecs[i].exp, vecs[i].name);
    end

    // A write strobe without chipselect must not land.
    bus_if.address   = 2'd1;
    bus_if.writedata = 32'h0;
    bus_if.write_n   = 1'b0;
    tick();
    bus_if.write_n = 1'b1;
    rd(2'd1, 32'hFF, "mask_cs_gate");

    // Clean press of key 0: event/irq on edge 6, DATA visible one read later.
    in_port        = 4'hE;
    bus_if.address = 2'd0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("press_irq", irq, (e >= 6));
      check("press_data", bus_if.readdata, (e >= 7) ? 32'h1 : 32'h0);
    end
    rd(2'd2, 32'h01, "press_event");
    // Release: DATA drops 6 edges later, no event.
    in_port        = 4'hF;
    bus_if.address = 2'd0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      check("release_data", bus_if.readdata, (e >= 7) ? 32'h0 : 32'h1);
    end
    rd(2'd2, 32'h01, "release_no_event");
    rd(2'd3, 32'h0, "release_status");
    repeat (25) tick();
    rd(2'd2, 32'h01, "no_repeat_after_release");
    bus_write(2'd2, 32'h01);
    rd(2'd2, 32'h0, "event_cleared");
    check("irq_after_clear", irq, 1'b0);

    // Bounce on key 1: 3-cycle toggles never settle; final low edge at c=30.
    bus_if.address = 2'd0;
    for (int c = 0; c <= 36; c++) begin
      in_port[1] = (c >= 30) ? 1'b0 : (((c / 3) % 2) == 1);
      tick();
      check("bounce_irq", irq, (c + 1 >= 36));
      check("bounce_data", bus_if.readdata, (c + 1 >= 37) ? 32'h2 : 32'h0);
    end
    rd(2'd2, 32'h02, "bounce_event");
    in_port = 4'hF;
    repeat (10) tick();
    bus_write(2'd2, 32'hFF);
    rd(2'd2, 32'h0, "bounce_cleared");

    // Hold key 2: repeats at 20/28/36 after stable press, each cleared at once.
    for (int c = 0; c < 60; c++) begin
      in_port = (c < 43) ? 4'hB : 4'hF;
      if (is_evt(c)) begin
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = 2'd2;
        bus_if.writedata  = 32'hFF;
      end else begin
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 2'd3;
      end
      tick();
      check("hold_irq", irq, is_evt(c + 1));
      if (!is_evt(c))
        check("hold_status", bus_if.readdata, ((c + 1 >= 27) && (c + 1 <= 49)) ? 32'h4 : 32'h0);
    end
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    rd(2'd2, 32'h0, "hold_no_late_repeat");

    // Clear race: W1C of bit 0 lands on the edge the press event sets.
    in_port = 4'hE;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = 2'd2;
        bus_if.writedata  = 32'h01;
      end
      tick();
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
    end
    check("race_irq", irq, 1'b1);
    rd(2'd2, 32'h01, "race_set_wins");
    in_port = 4'hF;
    repeat (10) tick();
    bus_write(2'd2, 32'hFF);
    rd(2'd2, 32'h0, "race_cleared");

    // Interrupt mask: only key 1 enabled.
    bus_write(2'd1, 32'h02);
    in_port = 4'hE;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("mask_key0_irq", irq, 1'b0);
    end
    in_port = 4'hC;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("mask_key1_irq", irq, (e >= 6));
    end
    bus_write(2'd2, 32'h02);
    check("mask_irq_drop", irq, 1'b0);
    in_port = 4'hF;
    rd(2'd2, 32'h01, "mask_event_key0");
    repeat (10) tick();
    bus_write(2'd2, 32'hFF);
    bus_write(2'd1, 32'hFF);
    rd(2'd2, 32'h0, "mask_cleared");

    // Reset while key 3 is in the repeat phase.
    in_port = 4'h7;
    repeat (29) tick();
    rd(2'd3, 32'h8, "status_key3_held");
    check("pre_reset_irq", irq, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_readdata", bus_if.readdata, 32'h0);
    check("rst_mid_irq", irq, 1'b0);
    rd(2'd0, 32'h0, "rst_mid_data");
    rd(2'd1, 32'h0, "rst_mid_mask");
    rd(2'd2, 32'h0, "rst_mid_event");
    rd(2'd3, 32'h0, "rst_mid_status");
    bus_if.address = 2'd2;
    tick();
    check("rst_refire_early5", bus_if.readdata, 32'h0);
    tick();
    check("rst_refire_early6", bus_if.readdata, 32'h0);
    tick();
    check("rst_refire_event", bus_if.readdata, 32'h8);
    check("rst_refire_irq", irq, 1'b0);
    rd(2'd0, 32'h8, "rst_refire_data");
    in_port = 4'hF;
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
